// File: rtl/xsum_rx.sv
// Receive side of the inter-Xilinx partial-sum link: word qualification, lock FSM,
// registered xdata/xcomma output and error statistics. Optional lostcnt via XRX_LOSTCNT_EN.
module xsum_rx #(
  parameter int LOCKCNT = 16,
  parameter int ELOSS   = 4,
  parameter int ERRBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        rxdata,
  input  logic               rxk,
  input  logic               rxerr,
  input  logic               errclr,
  output logic [15:0]        xdata,
  output logic               xcomma,
  output logic               locked,
  output logic [ERRBITS-1:0] errcnt,
  output logic [7:0]         lostcnt
);

  localparam logic [15:0] COMMA = 16'h00BC;
  localparam int GW = $clog2(LOCKCNT + 1);
  localparam int BW = $clog2(ELOSS + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCKCNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(ELOSS - 1);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] goodrun, goodrun_nxt;
  logic [BW-1:0] badrun, badrun_nxt;
  logic          good_data, good_comma, bad;
  logic          err_inc, pass;

  assign good_data  = !rxk && !rxerr;
  assign good_comma = rxk && !rxerr && (rxdata == COMMA);
  assign bad        = !(good_data || good_comma);

  // Only a clean data word seen while already locked is forwarded.
  assign pass = (state == LOCKED) && good_data;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    goodrun_nxt = goodrun;
    badrun_nxt  = badrun;
    err_inc     = 1'b0;
    unique case (state)
      HUNT: begin
        if (good_comma) begin
          state_nxt   = SYNC;
          goodrun_nxt = '0;
        end
      end
      SYNC: begin
        if (bad) begin
          state_nxt = HUNT;
          err_inc   = 1'b1;
        end else if (goodrun == GOOD_LAST) begin
          state_nxt  = LOCKED;
          badrun_nxt = '0;
        end else begin
          goodrun_nxt = goodrun + 1'b1;
        end
      end
      LOCKED: begin
        if (bad) begin
          err_inc = 1'b1;
          if (badrun == BAD_LAST) begin
            state_nxt = HUNT;
          end else begin
            badrun_nxt = badrun + 1'b1;
          end
        end else begin
          badrun_nxt = '0;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HUNT;
      goodrun <= '0;
      badrun  <= '0;
      xdata   <= COMMA;
      xcomma  <= 1'b1;
      locked  <= 1'b0;
    end else begin
      state   <= state_nxt;
      goodrun <= goodrun_nxt;
      badrun  <= badrun_nxt;
      xdata   <= pass ? rxdata : COMMA;
      xcomma  <= !pass;
      locked  <= (state_nxt == LOCKED);
    end
  end

  // errclr wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset || errclr) begin
      errcnt <= '0;
    end else if (err_inc && (errcnt != '1)) begin
      errcnt <= errcnt + 1'b1;
    end
  end

`ifdef XRX_LOSTCNT_EN
  logic lost_inc;
  assign lost_inc = (state == LOCKED) && bad && (badrun == BAD_LAST);

  always_ff @(posedge clk) begin
    if (reset || errclr) begin
      lostcnt <= '0;
    end else if (lost_inc && (lostcnt != 8'hFF)) begin
      lostcnt <= lostcnt + 1'b1;
    end
  end
`else
  assign lostcnt = 8'h00;
`endif

endmodule
